game_flow_ctrl: RTL



---
 rtl/game_flow_ctrl_pkg.sv | 15 +
 rtl/game_flow_ctrl_if.sv | 25 ++
 rtl/game_flow_ctrl_edge_detect.sv | 34 +++
 rtl/game_flow_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and defaults for the game-flow sequencer.
// State encoding is visible on the debug LEDs, so the order below is fixed.
package game_flow_ctrl_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        WAIT_PEER = 3'd1,
        COUNTDOWN = 3'd2,
        PLAY      = 3'd3,
        RESULT    = 3'd4
    } game_state_t;

    localparam int FPS_DEFAULT = 60;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game-flow sequencer and its neighbours.
// The slave side is the sequencer; the master side drives timing, buttons and the peer link.
interface game_flow_ctrl_if;
    logic       vblnk;
    logic       local_start;
    logic       remote_ready;
    logic       game_over;
    logic       local_win;
    logic       start_game;
    logic       local_ready;
    logic [2:0] countdown_sec;
    logic       show_result;
    logic       result_win;
    logic [2:0] state;

    modport master (
        output vblnk, local_start, remote_ready, game_over, local_win,
        input  start_game, local_ready, countdown_sec, show_result, result_win, state
    );

    modport slave (
        input  vblnk, local_start, remote_ready, game_over, local_win,
        output start_game, local_ready, countdown_sec, show_result, result_win, state
    );
endinterface

// File: rtl/game_flow_ctrl_edge_detect.sv
// Registered rising-edge detector producing a one-cycle pulse.
// With SKIP_FIRST set, the first rising edge after reset is swallowed.
module edge_detect #(
    parameter bit SKIP_FIRST = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_prev;
    logic r_armed;
    logic r_pulse;
    logic w_rise;

    assign w_rise  = i_sig & ~r_prev;
    assign o_pulse = r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= ~SKIP_FIRST;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_sig;
            r_pulse <= w_rise & r_armed;
            if (w_rise) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: menu, peer handshake, countdown, play and result hold.
// Frame timing comes from vertical-blank edges; all outputs are registered.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int FPS           = FPS_DEFAULT,
    parameter int COUNTDOWN_SEC = 3,
    parameter int RESULT_FRAMES = 300
) (
    input  logic              clk,
    input  logic              rst_n,
    game_flow_ctrl_if.slave   bus
);

    localparam int MAX_FRAMES = (FPS > RESULT_FRAMES) ? FPS : RESULT_FRAMES;
    localparam int FCW        = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [FCW-1:0] FPS_LAST = FCW'(FPS - 1);
    localparam logic [FCW-1:0] RES_LAST = FCW'(RESULT_FRAMES - 1);
    localparam logic [2:0]     SEC_INIT = 3'(COUNTDOWN_SEC);

    logic w_tick;
    logic w_press;

    game_state_t    r_state;
    logic [FCW-1:0] r_frame_cnt;
    logic [2:0]     r_sec_cnt;
    logic           r_win;

    logic       r_start_game;
    logic       r_local_ready;
    logic [2:0] r_countdown_sec;
    logic       r_show_result;
    logic       r_result_win;
    logic [2:0] r_state_out;

    edge_detect #(.SKIP_FIRST(1'b1)) u_vblnk_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (bus.vblnk),
        .o_pulse (w_tick)
    );

    edge_detect #(.SKIP_FIRST(1'b0)) u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (bus.local_start),
        .o_pulse (w_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= MENU;
            r_frame_cnt     <= '0;
            r_sec_cnt       <= 3'd0;
            r_win           <= 1'b0;
            r_start_game    <= 1'b0;
            r_local_ready   <= 1'b0;
            r_countdown_sec <= 3'd0;
            r_show_result   <= 1'b0;
            r_result_win    <= 1'b0;
            r_state_out     <= 3'd0;
        end else begin
            // Outputs follow the state/counter values one cycle later.
            r_start_game    <= (r_state == PLAY) || (r_state == RESULT);
            r_local_ready   <= (r_state == WAIT_PEER) || (r_state == COUNTDOWN);
            r_countdown_sec <= (r_state == COUNTDOWN) ? r_sec_cnt : 3'd0;
            r_show_result   <= (r_state == RESULT);
            r_result_win    <= r_win;
            r_state_out     <= r_state;

            case (r_state)
                MENU: begin
                    if (w_press) begin
                        if (bus.remote_ready) begin
                            r_state     <= COUNTDOWN;
                            r_sec_cnt   <= SEC_INIT;
                            r_frame_cnt <= '0;
                        end else begin
                            r_state <= WAIT_PEER;
                        end
                    end
                end
                WAIT_PEER: begin
                    if (w_press) begin
                        r_state <= MENU;
                    end else if (bus.remote_ready) begin
                        r_state     <= COUNTDOWN;
                        r_sec_cnt   <= SEC_INIT;
                        r_frame_cnt <= '0;
                    end
                end
                COUNTDOWN: begin
                    // Cancels outrank a same-cycle tick.
                    if (w_press) begin
                        r_state <= MENU;
                    end else if (!bus.remote_ready) begin
                        r_state <= WAIT_PEER;
                    end else if (w_tick) begin
                        if (r_frame_cnt == FPS_LAST) begin
                            r_frame_cnt <= '0;
                            r_sec_cnt   <= r_sec_cnt - 3'd1;
                            if (r_sec_cnt == 3'd1) begin
                                r_state <= PLAY;
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (bus.game_over) begin
                        r_state     <= RESULT;
                        r_win       <= bus.local_win;
                        r_frame_cnt <= '0;
                    end
                end
                RESULT: begin
                    if (w_tick) begin
                        if (r_frame_cnt == RES_LAST) begin
                            r_state     <= MENU;
                            r_frame_cnt <= '0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= MENU;
                end
            endcase
        end
    end

    assign bus.start_game    = r_start_game;
    assign bus.local_ready   = r_local_ready;
    assign bus.countdown_sec = r_countdown_sec;
    assign bus.show_result   = r_show_result;
    assign bus.result_win    = r_result_win;
    assign bus.state         = r_state_out;

endmodule
